acq_seq_ctrl: RTL and testbench

Acquisition sequencer for the sig_acq test path. It drives the clear and enable inputs of the test pulse generator through a programmed number of fixed-length frames, with optional idle gaps between frames. During each frame it counts rising edges on two pulse inputs and hands the per-frame counts to a downstream consumer over a valid/ready interface. It is the only block that owns the generator's `clr` and `ena` inputs.

---
 rtl/acq_seq_ctrl.sv | 170 +++++++++++++++++
 tb/tb_acq_seq_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acq_seq_ctrl.sv
// Acquisition sequencer: steps the test pulse generator through programmed frames,
// counts pulse edges per frame and hands the counts downstream over valid/ready.
module acq_seq_ctrl #(
    parameter int unsigned FRAME_LEN = 2048,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [15:0]      num_frames,
    input  logic [15:0]      gap_len,
    input  logic             pulse0_in,
    input  logic             pulse1_in,
    output logic             gen_clr,
    output logic             gen_ena,
    output logic             busy,
    output logic             done,
    output logic [15:0]      frame_cnt,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] res_edges0,
    output logic [CNT_W-1:0] res_edges1,
    output logic             overrun
);

    // WRAP is the single settle cycle after the final frame end, so done trails
    // the last result by one cycle.
    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_RUN, S_GAP, S_WRAP, S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [15:0]        r_num_frames;
    logic [15:0]        r_gap_len;
    logic [31:0]        r_cnt;
    logic [CNT_W-1:0]   r_edges0;
    logic [CNT_W-1:0]   r_edges1;
    logic               r_p0_d;
    logic               r_p1_d;
    logic               r_stop_pending;

    logic               w_start_acc;
    logic               w_frame_end;
    logic               w_gap_end;
    logic               w_last;
    logic               w_xfer;
    logic [15:0]        w_frame_cnt_nxt;
    logic [CNT_W-1:0]   w_edges0_nxt;
    logic [CNT_W-1:0]   w_edges1_nxt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic hit);
        return (hit && (v != '1)) ? v + 1'b1 : v;
    endfunction

    assign w_start_acc     = (r_state == S_IDLE) && start;
    assign w_frame_end     = (r_state == S_RUN) && (r_cnt == FRAME_LEN - 1);
    assign w_gap_end       = (r_cnt == 32'(r_gap_len) - 32'd1);
    assign w_frame_cnt_nxt = frame_cnt + 16'd1;
    assign w_last          = ((r_num_frames != 16'd0) && (w_frame_cnt_nxt == r_num_frames))
                             || r_stop_pending || stop;
    assign w_xfer          = res_valid && res_ready;
    assign w_edges0_nxt    = sat_inc(r_edges0, pulse0_in && !r_p0_d);
    assign w_edges1_nxt    = sat_inc(r_edges1, pulse1_in && !r_p1_d);

    // NOTE: w_next gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start) w_next = S_ARM;
            S_ARM:  w_next = stop ? S_DONE : S_RUN;
            S_RUN: begin
                if (w_frame_end) begin
                    if (w_last)                  w_next = S_WRAP;
                    else if (r_gap_len != 16'd0) w_next = S_GAP;
                    else                         w_next = S_ARM;
                end
            end
            S_GAP: begin
                if (stop)           w_next = S_DONE;
                else if (w_gap_end) w_next = S_ARM;
            end
            S_WRAP:  w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // NOTE: outputs decode the next state so they are registered yet aligned with the state they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            gen_clr <= 1'b1;
            gen_ena <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            r_state <= w_next;
            gen_clr <= (w_next != S_RUN);
            gen_ena <= (w_next == S_RUN);
            busy    <= (w_next != S_IDLE);
            done    <= (w_next == S_DONE);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_num_frames   <= '0;
            r_gap_len      <= '0;
            r_stop_pending <= 1'b0;
            r_cnt          <= '0;
            r_edges0       <= '0;
            r_edges1       <= '0;
            r_p0_d         <= 1'b0;
            r_p1_d         <= 1'b0;
        end else begin
            r_p0_d <= pulse0_in;
            r_p1_d <= pulse1_in;
            if (w_start_acc) begin
                r_num_frames   <= num_frames;
                r_gap_len      <= gap_len;
                r_stop_pending <= 1'b0;
            end else if ((r_state == S_RUN) && stop) begin
                r_stop_pending <= 1'b1;
            end
            // One counter times both RUN and GAP; it restarts at every frame end.
            case (r_state)
                S_RUN: begin
                    r_cnt    <= w_frame_end ? 32'd0 : r_cnt + 32'd1;
                    r_edges0 <= w_edges0_nxt;
                    r_edges1 <= w_edges1_nxt;
                end
                S_GAP:   r_cnt <= r_cnt + 32'd1;
                S_ARM: begin
                    r_cnt    <= '0;
                    r_edges0 <= '0;
                    r_edges1 <= '0;
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt  <= '0;
            res_valid  <= 1'b0;
            res_edges0 <= '0;
            res_edges1 <= '0;
            overrun    <= 1'b0;
        end else begin
            if (w_start_acc) begin
                frame_cnt <= '0;
                overrun   <= 1'b0;
            end
            // A frame end always loads; it only counts as lost data if the old result was not taken.
            if (w_frame_end) begin
                res_edges0 <= w_edges0_nxt;
                res_edges1 <= w_edges1_nxt;
                res_valid  <= 1'b1;
                frame_cnt  <= w_frame_cnt_nxt;
                if (res_valid && !res_ready) overrun <= 1'b1;
            end else if (w_xfer) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_acq_seq_ctrl.sv
// Directed bench for acq_seq_ctrl: a 2048-cycle-frame instance with a modelled pulse
// generator, plus a 64-cycle, 4-bit-counter instance for saturation.
module tb_acq_seq_ctrl;

    localparam int F = 2048;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int          cyc = 0;

    logic        start, stop, res_ready, man_p0;
    logic [15:0] num_frames, gap_len;
    logic        pulse0_in, pulse1_in;
    logic        gen_clr, gen_ena, busy, done, res_valid, overrun;
    logic [15:0] frame_cnt, res_edges0, res_edges1;

    logic        start1, p0_1;
    logic        d1_gen_clr, d1_gen_ena, d1_busy, d1_done, d1_res_valid, d1_overrun;
    logic [15:0] d1_frame_cnt;
    logic [3:0]  d1_res_edges0, d1_res_edges1;

    logic [15:0] gcnt;
    int          total = 0;
    int          bad = 0;
    int          n_done = 0;
    int          n_xfer = 0;
    logic [15:0] xe0 [0:63];
    logic [15:0] xe1 [0:63];
    int          t, d, nd0, nx0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Generator model: cleared by gen_clr, counts while enabled; pulse0 rises twice, pulse1 once per frame.
    always @(posedge clk or negedge rst) begin
        if (!rst)         gcnt <= '0;
        else if (gen_clr) gcnt <= '0;
        else if (gen_ena) gcnt <= gcnt + 16'd1;
    end
    assign pulse0_in = man_p0 || (gcnt >= 16'd10 && gcnt < 16'd12) || (gcnt >= 16'd100 && gcnt < 16'd105);
    assign pulse1_in = (gcnt >= 16'd50 && gcnt < 16'd60);

    acq_seq_ctrl #(.FRAME_LEN(F), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .num_frames(num_frames), .gap_len(gap_len),
        .pulse0_in(pulse0_in), .pulse1_in(pulse1_in),
        .gen_clr(gen_clr), .gen_ena(gen_ena), .busy(busy), .done(done),
        .frame_cnt(frame_cnt), .res_valid(res_valid), .res_ready(res_ready),
        .res_edges0(res_edges0), .res_edges1(res_edges1), .overrun(overrun)
    );

    acq_seq_ctrl #(.FRAME_LEN(64), .CNT_W(4)) u_dut_sat (
        .clk(clk), .rst(rst), .start(start1), .stop(1'b0),
        .num_frames(16'd1), .gap_len(16'd0),
        .pulse0_in(p0_1), .pulse1_in(1'b0),
        .gen_clr(d1_gen_clr), .gen_ena(d1_gen_ena), .busy(d1_busy), .done(d1_done),
        .frame_cnt(d1_frame_cnt), .res_valid(d1_res_valid), .res_ready(1'b1),
        .res_edges0(d1_res_edges0), .res_edges1(d1_res_edges1), .overrun(d1_overrun)
    );

    // Result and done log, sampled mid-cycle.
    always @(negedge clk) begin
        if (done) n_done <= n_done + 1;
        if (res_valid && res_ready) begin
            if (n_xfer < 64) begin
                xe0[n_xfer] <= res_edges0;
                xe1[n_xfer] <= res_edges1;
            end
            n_xfer <= n_xfer + 1;
        end
    end

    initial begin
        p0_1 = 1'b0;
        forever begin
            repeat (2) @(posedge clk);
            #1 p0_1 = ~p0_1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Lands 1 time unit after the posedge that opens cycle c.
    task automatic at_cycle(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic kick(input logic [15:0] n, input logic [15:0] g, output int ts);
        num_frames = n;
        gap_len    = g;
        start      = 1'b1;
        ts         = cyc;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    initial begin
        start = 0; stop = 0; num_frames = 0; gap_len = 0; res_ready = 1; man_p0 = 0; start1 = 0;

        at_cycle(2);
        check("rst gen_clr", gen_clr, 1);
        check("rst ena/busy/done", {gen_ena, busy, done}, 0);
        check("rst frame_cnt", frame_cnt, 0);
        check("rst valid/overrun", {res_valid, overrun}, 0);
        check("rst edges", {res_edges0, res_edges1}, 0);
        check("rst sat gen_clr", d1_gen_clr, 1);
        rst = 1'b1;

        at_cycle(5);
        stop = 1'b1;
        at_cycle(8);
        check("idle stop busy", busy, 0);
        stop = 1'b0;
        at_cycle(11);
        check("idle stop no done", n_done, 0);
        check("idle stop gen_clr", gen_clr, 1);

        // Three frames with 10-cycle gaps; the saturation instance runs alongside.
        nd0 = n_done; nx0 = n_xfer;
        start1 = 1'b1;
        kick(16'd3, 16'd10, t);
        start1 = 1'b0;
        check("arm busy", busy, 1);
        check("arm gen_clr", gen_clr, 1);
        check("arm gen_ena", gen_ena, 0);
        at_cycle(t + 2);
        check("run gen_ena", gen_ena, 1);
        check("run gen_clr", gen_clr, 0);
        at_cycle(t + 100);
        check("sat edges0", d1_res_edges0, 15);
        check("sat edges1", d1_res_edges1, 0);
        check("sat frame_cnt", d1_frame_cnt, 1);
        check("sat busy", d1_busy, 0);
        at_cycle(t + 1 + F);
        check("last run gen_ena", gen_ena, 1);
        check("no early result", res_valid, 0);
        at_cycle(t + 2 + F);
        check("first res_valid", res_valid, 1);
        check("first frame_cnt", frame_cnt, 1);
        check("gap gen_clr", gen_clr, 1);
        at_cycle(t + 12 + F);
        check("arm after gap ena", gen_ena, 0);
        check("arm after gap busy", busy, 1);
        at_cycle(t + 13 + F);
        check("second run ena", gen_ena, 1);
        d = t + 2 + 3 * (F + 1) + 2 * 10;
        at_cycle(d - 1);
        check("no early done", n_done - nd0, 0);
        at_cycle(d);
        check("done at end", done, 1);
        check("busy at done", busy, 1);
        at_cycle(d + 1);
        check("busy falls", busy, 0);
        check("done one cycle", done, 0);
        at_cycle(d + 3);
        check("one done", n_done - nd0, 1);
        check("three results", n_xfer - nx0, 3);
        for (int k = 0; k < 3; k++) begin
            check("result edges0", xe0[nx0 + k], 2);
            check("result edges1", xe1[nx0 + k], 1);
        end
        check("final frame_cnt", frame_cnt, 3);
        check("no overrun", overrun, 0);

        // Zero gap, start and stop together, start while busy.
        nd0 = n_done; nx0 = n_xfer;
        stop = 1'b1;
        kick(16'd2, 16'd0, t);
        stop = 1'b0;
        check("start+stop busy", busy, 1);
        at_cycle(t + 500);
        num_frames = 16'd7;
        start = 1'b1;
        at_cycle(t + 501);
        start = 1'b0;
        num_frames = 16'd2;
        at_cycle(t + 2 + F);
        check("zero gap arm ena", gen_ena, 0);
        check("zero gap arm clr", gen_clr, 1);
        check("zero gap frame_cnt", frame_cnt, 1);
        at_cycle(t + 3 + F);
        check("zero gap rerun", gen_ena, 1);
        d = t + 2 + 2 * (F + 1);
        at_cycle(d);
        check("zero gap done", done, 1);
        at_cycle(d + 2);
        check("zero gap one done", n_done - nd0, 1);
        check("zero gap two results", n_xfer - nx0, 2);
        check("zero gap frame_cnt end", frame_cnt, 2);
        check("zero gap idle", busy, 0);

        // Back-pressure over two frame ends; the second frame gets one extra pulse0 edge.
        nx0 = n_xfer;
        res_ready = 1'b0;
        kick(16'd2, 16'd0, t);
        at_cycle(t + 2 + F);
        check("bp first valid", res_valid, 1);
        check("bp no overrun yet", overrun, 0);
        check("bp first edges0", res_edges0, 2);
        at_cycle(t + F + 503);
        man_p0 = 1'b1;
        at_cycle(t + F + 504);
        man_p0 = 1'b0;
        at_cycle(t + 2 * F + 3);
        check("bp overrun", overrun, 1);
        check("bp still valid", res_valid, 1);
        check("bp second edges0", res_edges0, 3);
        check("bp second edges1", res_edges1, 1);
        check("bp frame_cnt", frame_cnt, 2);
        at_cycle(t + 2 * F + 9);
        res_ready = 1'b1;
        at_cycle(t + 2 * F + 10);
        check("bp valid drops", res_valid, 0);
        check("bp overrun sticky", overrun, 1);
        at_cycle(t + 2 * F + 12);
        check("bp one transfer", n_xfer - nx0, 1);
        check("bp transfer edges0", xe0[nx0], 3);

        // Continuous mode, stop at RUN cycle 100.
        nd0 = n_done; nx0 = n_xfer;
        kick(16'd0, 16'd5, t);
        check("overrun cleared", overrun, 0);
        at_cycle(t + 102);
        stop = 1'b1;
        at_cycle(t + 103);
        stop = 1'b0;
        at_cycle(t + 2 + F);
        check("stop run result", res_valid, 1);
        check("stop run frame_cnt", frame_cnt, 1);
        at_cycle(t + 3 + F);
        check("stop run done", done, 1);
        at_cycle(t + 6 + F);
        check("stop run one done", n_done - nd0, 1);
        check("stop run one result", n_xfer - nx0, 1);
        check("stop run idle", busy, 0);

        // Stop during the gap.
        nd0 = n_done; nx0 = n_xfer;
        kick(16'd0, 16'd20, t);
        at_cycle(t + 7 + F);
        check("in gap clr", gen_clr, 1);
        check("in gap busy", busy, 1);
        stop = 1'b1;
        at_cycle(t + 8 + F);
        stop = 1'b0;
        check("stop gap done", done, 1);
        at_cycle(t + 11 + F);
        check("stop gap one done", n_done - nd0, 1);
        check("stop gap no new result", n_xfer - nx0, 1);
        check("stop gap frame_cnt", frame_cnt, 1);
        check("stop gap idle", busy, 0);

        // Reset while a result is pending and the next frame is running.
        res_ready = 1'b0;
        kick(16'd0, 16'd0, t);
        at_cycle(t + 2 + F);
        check("pre-reset valid", res_valid, 1);
        at_cycle(t + F + 100);
        rst = 1'b0;
        #1;
        check("mid rst gen_clr", gen_clr, 1);
        check("mid rst ena/busy/done", {gen_ena, busy, done}, 0);
        check("mid rst valid/overrun", {res_valid, overrun}, 0);
        check("mid rst frame_cnt", frame_cnt, 0);
        check("mid rst edges", {res_edges0, res_edges1}, 0);
        at_cycle(t + F + 103);
        rst = 1'b1;
        at_cycle(t + F + 106);
        check("post rst idle", busy, 0);
        check("post rst gen_clr", gen_clr, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
